// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver, 8 data bits LSB first, optional parity, one stop bit
module uart_rx (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic [5:0] Prescale,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   output logic       data_valid,
   output logic [7:0] P_DATA
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t     state;
   logic [5:0] p, ec, half;
   logic       pe, pt, par_err, stp_err, vote, last, at_mid;
   logic [2:0] smp, bit_cnt;
   logic [7:0] sr;
   assign half   = {1'b0, p[5:1]};
   assign vote   = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
   assign last   = ec == p - 6'd1;
   assign at_mid = ec == half + 6'd2;
   // three samples around mid-bit feed the majority vote
   always_ff @(posedge CLK) begin
      if (RST) smp <= '0;
      else if (state != IDLE) begin
         if (ec == half - 6'd1) smp[0] <= RX_IN;
         if (ec == half) smp[1] <= RX_IN;
         if (ec == half + 6'd1) smp[2] <= RX_IN;
      end
   end
   // frame FSM; frame settings are latched at start detection and held for the whole frame
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         p          <= '0;
         ec         <= '0;
         pe         <= 1'b0;
         pt         <= 1'b0;
         bit_cnt    <= '0;
         sr         <= '0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         data_valid <= 1'b0;
         P_DATA     <= '0;
      end else begin
         data_valid <= 1'b0;
         ec         <= last ? 6'd0 : ec + 6'd1;
         case (state)
            IDLE: begin
               ec <= '0;
               if (!RX_IN) begin
                  state   <= START;
                  p       <= Prescale;
                  pe      <= PAR_EN;
                  pt      <= PAR_TYP;
                  bit_cnt <= '0;
                  par_err <= 1'b0;
                  stp_err <= 1'b0;
               end
            end
            START: state <= (at_mid && vote) ? IDLE : last ? DATA : START;
            DATA: if (last) begin
               sr      <= {vote, sr[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= pe ? PARITY : STOP;
            end
            PARITY: if (last) begin
               par_err <= vote != (pt ? ~^sr : ^sr);
               state   <= STOP;
            end
            STOP: begin
               if (at_mid) stp_err <= !vote;
               if (last) begin
                  state <= IDLE;
                  if (!par_err && !stp_err) begin
                     P_DATA     <= sr;
                     data_valid <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed bytes, pulse counts and latencies
module tb_uart_rx;
   logic       CLK_tb = 1'b0;
   logic       RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic       data_valid;
   logic [7:0] P_DATA;
   int         cyc = 0, checks = 0, failures = 0;
   int         dv_q[$], dv_t[$];

   uart_rx dut (
      .CLK(CLK_tb), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .data_valid(data_valid), .P_DATA(P_DATA)
   );

   always #5 CLK_tb = ~CLK_tb;
   // free-running cycle count for latency measurement
   always @(posedge CLK_tb) cyc <= cyc + 1;
   // record every cycle data_valid is high, sampled mid-cycle
   always @(negedge CLK_tb) if (data_valid) begin
      dv_q.push_back(int'(P_DATA));
      dv_t.push_back(cyc);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge CLK_tb);
      #1;
   endtask

   // caller is always 1 time unit after a rising edge; ends one cycle after the stop bit
   task automatic send(input int pr, input logic pe, input logic pt, input logic [7:0] d,
                       input logic pb, input logic sb, output int t0);
      int n;
      n = pe ? 11 : 10;
      Prescale = 6'(pr);
      PAR_EN = pe;
      PAR_TYP = pt;
      t0 = cyc;
      for (int i = 0; i < n; i++) begin
         RX_IN = (i == 0) ? 1'b0 : (i < 9) ? d[i-1] : (pe && i == 9) ? pb : sb;
         wait_cyc(pr);
      end
      RX_IN = 1'b1;
      wait_cyc(1);
   endtask

   task automatic good(input string tag, input int pr, input logic pe, input logic pt,
                       input logic [7:0] d, input logic pb);
      int n0, t0;
      n0 = dv_q.size();
      send(pr, pe, pt, d, pb, 1'b1, t0);
      wait_cyc(4);
      chk({tag, " pulses"}, dv_q.size() - n0, 1);
      chk({tag, " byte"}, dv_q.size() > n0 ? dv_q[$] : -1, int'(d));
      chk({tag, " latency"}, dv_q.size() > n0 ? dv_t[$] - t0 - 1 : -1, (pe ? 11 : 10) * pr);
      chk({tag, " hold"}, int'(P_DATA), int'(d));
   endtask

   task automatic bad(input string tag, input logic [7:0] d, input logic pb, input logic sb,
                      input int prev);
      int n0, t0;
      n0 = dv_q.size();
      send(8, 1'b1, 1'b0, d, pb, sb, t0);
      wait_cyc(4);
      chk({tag, " pulses"}, dv_q.size() - n0, 0);
      chk({tag, " held"}, int'(P_DATA), prev);
   endtask

   initial begin
      int n0, t0, t1;
      wait_cyc(3);
      chk("reset P_DATA", int'(P_DATA), 0);
      chk("reset dv", int'(data_valid), 0);
      RST = 1'b0;
      wait_cyc(2);
      good("even BD", 8, 1'b1, 1'b0, 8'hBD, 1'b0);
      good("even F8", 8, 1'b1, 1'b0, 8'hF8, 1'b1);
      good("odd 89", 8, 1'b1, 1'b1, 8'h89, 1'b0);
      good("odd 78", 8, 1'b1, 1'b1, 8'h78, 1'b1);
      good("np 7C p8", 8, 1'b0, 1'b0, 8'h7C, 1'b0);
      good("np 7C p16", 16, 1'b0, 1'b0, 8'h7C, 1'b0);
      good("np 7C p32", 32, 1'b0, 1'b0, 8'h7C, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n0 = dv_q.size();
         send(8, 1'b0, 1'b0, 8'h7C, 1'b0, 1'b1, t0);
         send(8, k == 1, 1'b0, 8'h3F, 1'b0, 1'b1, t1);
         wait_cyc(4);
         chk(k ? "b2b par pulses" : "b2b pulses", dv_q.size() - n0, 2);
         chk(k ? "b2b par first" : "b2b first", dv_q.size() > n0 + 1 ? dv_q[n0] : -1, 'h7C);
         chk(k ? "b2b par second" : "b2b second", dv_q.size() > n0 + 1 ? dv_q[n0+1] : -1, 'h3F);
         chk(k ? "b2b par lat" : "b2b lat", dv_q.size() > n0 + 1 ? dv_t[n0+1] - t1 - 1 : -1,
             k ? 88 : 80);
      end
      bad("bad parity", 8'hBD, 1'b1, 1'b1, 'h3F);
      bad("bad stop", 8'hBD, 1'b0, 1'b0, 'h3F);
      n0 = dv_q.size();
      RX_IN = 1'b0;
      wait_cyc(2);
      RX_IN = 1'b1;
      wait_cyc(40);
      chk("glitch pulses", dv_q.size() - n0, 0);
      chk("glitch held", int'(P_DATA), 'h3F);
      good("after glitch", 8, 1'b1, 1'b0, 8'hF8, 1'b1);
      Prescale = 6'd8;
      PAR_EN = 1'b0;
      RX_IN = 1'b0;
      wait_cyc(8);
      RX_IN = 1'b1;
      wait_cyc(4);
      RST = 1'b1;
      wait_cyc(1);
      RST = 1'b0;
      chk("mid reset P_DATA", int'(P_DATA), 0);
      chk("mid reset dv", int'(data_valid), 0);
      n0 = dv_q.size();
      wait_cyc(100);
      chk("mid reset pulses", dv_q.size() - n0, 0);
      good("after reset", 8, 1'b1, 1'b0, 8'hBD, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
